// File: rtl/butterfly_feeder.sv
// Input-side pairing stage for one radix-2 FFT butterfly: buffers the first SPAN samples of
// each 2*SPAN block and pairs them with the second half, issuing twiddle index and aligned x0.
module butterfly_feeder #(
    parameter int unsigned totalbits = 30,
    parameter int unsigned SPAN      = 128,
    parameter int unsigned TW_DEPTH  = 128,
    parameter int unsigned ALIGN_LAT = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    input  logic [totalbits-1:0]                          in_real,
    input  logic [totalbits-1:0]                          in_imag,
    output logic                                          x1_valid,
    output logic [totalbits-1:0]                          x1_real,
    output logic [totalbits-1:0]                          x1_imag,
    output logic [(TW_DEPTH > 1 ? $clog2(TW_DEPTH) : 1)-1:0] tw_idx,
    output logic                                          x0_valid,
    output logic [totalbits-1:0]                          x0_real,
    output logic [totalbits-1:0]                          x0_imag,
    output logic                                          blk_done
);

    localparam int unsigned CntW   = $clog2(2 * SPAN);
    localparam int unsigned JW     = (SPAN > 1) ? $clog2(SPAN) : 1;
    localparam int unsigned TwW    = (TW_DEPTH > 1) ? $clog2(TW_DEPTH) : 1;
    localparam int unsigned TwStep = TW_DEPTH / SPAN;
    localparam int unsigned DW     = 2 * totalbits;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pair;
    logic [JW-1:0]   j;
    logic            accept_fill, accept_pair, last_pair;
    logic [DW-1:0]   rd_data;
    logic [TwW-1:0]  tw_d;

    logic [DW-1:0] mem_q [SPAN];

    logic                 x1_valid_q;
    logic [totalbits-1:0] x1_real_q, x1_imag_q;
    logic [TwW-1:0]       tw_idx_q;
    logic [DW-1:0]        pr_data_q;
    logic                 pr_last_q;

    logic          dl_vld_q  [ALIGN_LAT];
    logic          dl_last_q [ALIGN_LAT];
    logic [DW-1:0] dl_data_q [ALIGN_LAT];

    // Phase is the counter MSB; for SPAN=1 the mask forces j to 0.
    assign pair        = cnt_q[CntW-1];
    assign j           = JW'(cnt_q) & JW'(SPAN - 1);
    assign accept_fill = in_valid & ~pair;
    assign accept_pair = in_valid & pair;
    assign last_pair   = accept_pair & (j == JW'(SPAN - 1));
    assign rd_data     = mem_q[j];
    assign tw_d        = TwW'(32'(j) * TwStep);

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Sample buffer is not reset; every entry is written in FILL before PAIR reads it.
    always_ff @(posedge clk) begin
        if (accept_fill) begin
            mem_q[j] <= {in_real, in_imag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_valid_q <= 1'b0;
            x1_real_q  <= '0;
            x1_imag_q  <= '0;
            tw_idx_q   <= '0;
            pr_data_q  <= '0;
            pr_last_q  <= 1'b0;
        end else begin
            x1_valid_q <= accept_pair;
            pr_last_q  <= last_pair;
            if (accept_pair) begin
                x1_real_q <= in_real;
                x1_imag_q <= in_imag;
                tw_idx_q  <= tw_d;
                pr_data_q <= rd_data;
            end
        end
    end

    // Valid/last shift every cycle; data only moves with a valid entry so outputs hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ALIGN_LAT; i++) begin
                dl_vld_q[i]  <= 1'b0;
                dl_last_q[i] <= 1'b0;
                dl_data_q[i] <= '0;
            end
        end else begin
            dl_vld_q[0]  <= x1_valid_q;
            dl_last_q[0] <= x1_valid_q & pr_last_q;
            if (x1_valid_q) begin
                dl_data_q[0] <= pr_data_q;
            end
            for (int i = 1; i < ALIGN_LAT; i++) begin
                dl_vld_q[i]  <= dl_vld_q[i-1];
                dl_last_q[i] <= dl_last_q[i-1];
                if (dl_vld_q[i-1]) begin
                    dl_data_q[i] <= dl_data_q[i-1];
                end
            end
        end
    end

    assign x1_valid = x1_valid_q;
    assign x1_real  = x1_real_q;
    assign x1_imag  = x1_imag_q;
    assign tw_idx   = tw_idx_q;
    assign x0_valid = dl_vld_q[ALIGN_LAT-1];
    assign x0_real  = dl_data_q[ALIGN_LAT-1][DW-1:totalbits];
    assign x0_imag  = dl_data_q[ALIGN_LAT-1][totalbits-1:0];
    assign blk_done = dl_last_q[ALIGN_LAT-1];

endmodule

// File: tb/tb_butterfly_feeder.sv
// Scoreboard bench: DUT a (SPAN=4, ALIGN_LAT=1) for functional cases, DUT b (SPAN=128,
// ALIGN_LAT=3) for extremes. Drivers push expectations; a negedge monitor pops and compares.
module tb_butterfly_feeder;

    localparam int W = 30;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        int unsigned  tw;
        bit           last;
        longint       cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         va = 1'b0, vb = 1'b0;
    logic [W-1:0] ra = '0, ia = '0, rb = '0, ib = '0;
    logic         x1v_a, x0v_a, bd_a, x1v_b, x0v_b, bd_b;
    logic [W-1:0] x1r_a, x1i_a, x0r_a, x0i_a, x1r_b, x1i_b, x0r_b, x0i_b;
    logic [6:0]   tw_a, tw_b;

    butterfly_feeder #(.totalbits(W), .SPAN(4), .TW_DEPTH(128), .ALIGN_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_real(ra), .in_imag(ia),
        .x1_valid(x1v_a), .x1_real(x1r_a), .x1_imag(x1i_a), .tw_idx(tw_a),
        .x0_valid(x0v_a), .x0_real(x0r_a), .x0_imag(x0i_a), .blk_done(bd_a)
    );

    butterfly_feeder #(.totalbits(W), .SPAN(128), .TW_DEPTH(128), .ALIGN_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_real(rb), .in_imag(ib),
        .x1_valid(x1v_b), .x1_real(x1r_b), .x1_imag(x1i_b), .tw_idx(tw_b),
        .x0_valid(x0v_b), .x0_real(x0r_b), .x0_imag(x0i_b), .blk_done(bd_b)
    );

    int           ntests = 0;
    int           nfail  = 0;
    longint       cyc    = 0;
    exp_t         q1a[$], q0a[$], q1b[$], q0b[$];
    int           mcnt[2];
    logic [2*W-1:0] mmem[2][128];
    int           nblk_a = 0;
    longint       blk_prev = 0, blk_last = 0;
    logic [W-1:0] tre, tim;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        ntests++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int qsize(input int d, input int k);
        if (d == 0) return (k == 1) ? q1a.size() : q0a.size();
        return (k == 1) ? q1b.size() : q0b.size();
    endfunction

    function automatic exp_t qpop(input int d, input int k);
        if (d == 0) return (k == 1) ? q1a.pop_front() : q0a.pop_front();
        return (k == 1) ? q1b.pop_front() : q0b.pop_front();
    endfunction

    task automatic qpush(input int d, input int k, input exp_t e);
        if (d == 0 && k == 1) q1a.push_back(e);
        else if (d == 0) q0a.push_back(e);
        else if (k == 1) q1b.push_back(e);
        else q0b.push_back(e);
    endtask

    // Reference pairing model: sample accepted at the coming edge shows on x1 at that edge.
    task automatic model(input int d, input logic [W-1:0] re, input logic [W-1:0] im);
        int   span, al, j;
        exp_t e;
        span = (d != 0) ? 128 : 4;
        al   = (d != 0) ? 3 : 1;
        j    = mcnt[d] % span;
        if (mcnt[d] < span) begin
            mmem[d][j] = {re, im};
        end else begin
            e.re = re; e.im = im; e.tw = j * (128 / span); e.last = 1'b0; e.cyc = cyc + 1;
            qpush(d, 1, e);
            e.re   = mmem[d][j][2*W-1:W];
            e.im   = mmem[d][j][W-1:0];
            e.last = (j == span - 1);
            e.cyc  = cyc + 1 + al;
            qpush(d, 0, e);
        end
        mcnt[d] = (mcnt[d] + 1) % (2 * span);
    endtask

    task automatic step(input int d, input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
        if (d == 0) begin va = v; ra = re; ia = im; end
        else begin vb = v; rb = re; ib = im; end
        if (v && !rst) model(d, re, im);
        @(posedge clk);
        #1;
        va = 1'b0;
        vb = 1'b0;
    endtask

    task automatic mon(input int d, input logic v1, input logic [W-1:0] r1, input logic [W-1:0] i1,
                       input logic [6:0] tw, input logic v0, input logic [W-1:0] r0,
                       input logic [W-1:0] i0, input logic bd);
        exp_t  e;
        string p;
        p = (d != 0) ? "b" : "a";
        if (v1) begin
            if (qsize(d, 1) == 0) check({"x1", p, "_unexpected_valid"}, 1, 0);
            else begin
                e = qpop(d, 1);
                check({"x1", p, "_real"}, r1, e.re);
                check({"x1", p, "_imag"}, i1, e.im);
                check({"x1", p, "_tw_idx"}, tw, e.tw);
                check({"x1", p, "_cycle"}, cyc, e.cyc);
            end
        end
        if (v0) begin
            if (qsize(d, 0) == 0) check({"x0", p, "_unexpected_valid"}, 1, 0);
            else begin
                e = qpop(d, 0);
                check({"x0", p, "_real"}, r0, e.re);
                check({"x0", p, "_imag"}, i0, e.im);
                check({"x0", p, "_blk_done"}, bd, e.last);
                check({"x0", p, "_cycle"}, cyc, e.cyc);
            end
        end else if (bd) begin
            check({"blk_done_", p, "_without_x0"}, 1, 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, x1v_a, x1r_a, x1i_a, tw_a, x0v_a, x0r_a, x0i_a, bd_a);
            mon(1, x1v_b, x1r_b, x1i_b, tw_b, x0v_b, x0r_b, x0i_b, bd_b);
            if (bd_a) begin
                blk_prev = blk_last;
                blk_last = cyc;
                nblk_a++;
            end
        end
    end

    initial begin
        int n0;
        mcnt[0] = 0;
        mcnt[1] = 0;
        @(posedge clk);
        #1;

        // Reset held with in_valid high: nothing may come out.
        for (int k = 0; k < 3; k++) begin
            va = 1'b1; ra = 30'd77; ia = 30'(-77);
            @(posedge clk);
            #1;
            check("rst_x1_valid", x1v_a, 0);
            check("rst_x0_valid", x0v_a, 0);
            check("rst_blk_done", bd_a, 0);
            check("rst_x1_real", x1r_a, 0);
            check("rst_x0_imag", x0i_a, 0);
            check("rst_tw_idx", tw_a, 0);
            check("rst_b_valids", {x1v_b, x0v_b}, 0);
        end
        va  = 1'b0;
        rst = 1'b0;

        // Contiguous block 1..8 / -1..-8.
        for (int i = 1; i <= 8; i++) step(0, 1'b1, 30'(i), 30'(-i));
        for (int k = 0; k < 3; k++) step(0, 1'b0, '0, '0);

        // Gapped input with junk data on idle cycles.
        for (int i = 1; i <= 8; i++) begin
            step(0, 1'b1, 30'(i), 30'(-i));
            step(0, 1'b0, 30'h3ABCDEF, 30'h1234567);
        end
        for (int k = 0; k < 3; k++) step(0, 1'b0, '0, '0);

        // Back-to-back blocks.
        n0 = nblk_a;
        for (int i = 1; i <= 16; i++) step(0, 1'b1, 30'(i), 30'(-i));
        for (int k = 0; k < 4; k++) step(0, 1'b0, '0, '0);
        check("b2b_blk_count", nblk_a - n0, 2);
        check("b2b_blk_spacing", blk_last - blk_prev, 8);

        // Reset after 6 of 8 inputs; outputs must clear without waiting for an edge.
        for (int i = 1; i <= 6; i++) step(0, 1'b1, 30'(i + 100), 30'(-(i + 100)));
        rst = 1'b1;
        q1a.delete(); q0a.delete(); q1b.delete(); q0b.delete();
        mcnt[0] = 0;
        mcnt[1] = 0;
        #1;
        check("rst_async_x1_valid", x1v_a, 0);
        check("rst_async_x0_valid", x0v_a, 0);
        check("rst_async_x1_real", x1r_a, 0);
        check("rst_async_x0_real", x0r_a, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) step(0, 1'b1, 30'(i + 200), 30'(-(i + 200)));
        for (int k = 0; k < 4; k++) step(0, 1'b0, '0, '0);

        // Extremes on the full-size instance.
        for (int i = 0; i < 256; i++) begin
            case (i)
                0:       begin tre = 30'h1FFFFFFF; tim = 30'h20000000; end
                1:       begin tre = 30'h20000001; tim = 30'h1FFFFFFF; end
                128:     begin tre = 30'h20000000; tim = 30'h20000001; end
                129:     begin tre = 30'h1FFFFFFF; tim = 30'h20000000; end
                default: begin tre = 30'(i * 32'h9E3779B1); tim = ~tre; end
            endcase
            step(1, 1'b1, tre, tim);
        end
        for (int k = 0; k < 8; k++) step(1, 1'b0, '0, '0);

        check("drain_x1a", q1a.size(), 0);
        check("drain_x0a", q0a.size(), 0);
        check("drain_x1b", q1b.size(), 0);
        check("drain_x0b", q0b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
